// File: rtl/spr_dma_pkg.sv
// spr_dma_pkg: shared state encoding and default bus addresses for the sprite DMA engine
package spr_dma_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, DONE = 2'd3} state_t;
  localparam logic [15:0] TRIG_ADDR_DEF = 16'h4014;
  localparam logic [15:0] DST_ADDR_DEF = 16'h2004;
endpackage

// File: rtl/spr_dma_addr_gen.sv
// spr_dma_addr_gen: master bus address; source page walk in RD, fixed or incrementing destination in WR
module spr_dma_addr_gen
  import spr_dma_pkg::*;
#(
  parameter logic [15:0] DST_ADDR = DST_ADDR_DEF,
  parameter int DST_INC = 0,
  parameter int CW = 9
)(
  input  state_t         i_state,
  input  logic [7:0]     i_page,
  input  logic [CW-1:0]  i_cnt,
  output logic [15:0]    o_spr_addr
);
  logic [15:0] w_off;
  assign w_off = 16'(i_cnt);
  assign o_spr_addr = i_state == RD ? {i_page, 8'h00} + w_off :
                      i_state == WR ? DST_ADDR + (DST_INC != 0 ? w_off : 16'h0) : 16'h0;
endmodule

// File: rtl/spr_dma_engine.sv
// spr_dma_engine: trigger-started DMA moving XFER_LEN bytes from a CPU page to a destination.
// Optional i_abort input enabled by defining SPR_DMA_ABORT_EN.
module spr_dma_engine
  import spr_dma_pkg::*;
#(
  parameter logic [15:0] TRIG_ADDR = TRIG_ADDR_DEF,
  parameter logic [15:0] DST_ADDR = DST_ADDR_DEF,
  parameter int XFER_LEN = 256,
  parameter int DST_INC = 0
)(
`ifdef SPR_DMA_ABORT_EN
  input  logic        i_abort,
`endif
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_bus_addr,
  input  logic        i_bus_wn,
  input  logic [7:0]  i_bus_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_spr_req,
  input  logic        i_spr_gnt,
  output logic [15:0] o_spr_addr,
  output logic        o_spr_wn,
  output logic [7:0]  o_spr_wdata,
  input  logic [7:0]  i_spr_rdata
);
  localparam int CW = $clog2(XFER_LEN + 1);
  state_t        r_state;
  logic [7:0]    r_page, r_buf;
  logic [CW-1:0] r_cnt;
  logic          w_act, w_trig, w_last, w_abort;
  assign w_act  = r_state == RD || r_state == WR;
  assign w_trig = r_state == IDLE && i_bus_addr == TRIG_ADDR && !i_bus_wn;
  assign w_last = r_cnt == CW'(XFER_LEN - 1);
`ifdef SPR_DMA_ABORT_EN
  assign w_abort = i_abort & w_act;
`else
  assign w_abort = 1'b0;
`endif
  // abort outranks a same-cycle grant so the pending beat is never committed
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_page  <= 8'h00;
      r_buf   <= 8'h00;
      r_cnt   <= '0;
    end else if (w_abort) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: if (w_trig) begin
          r_state <= RD;
          r_page  <= i_bus_wdata;
          r_cnt   <= '0;
        end
        RD: if (i_spr_gnt) begin
          r_buf   <= i_spr_rdata;
          r_state <= WR;
        end
        WR: if (i_spr_gnt) begin
          r_cnt   <= r_cnt + 1'b1;
          r_state <= w_last ? DONE : RD;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign o_busy      = r_state != IDLE;
  assign o_done      = r_state == DONE;
  assign o_spr_req   = w_act;
  assign o_spr_wn    = r_state != WR;
  assign o_spr_wdata = r_buf;
  spr_dma_addr_gen #(.DST_ADDR(DST_ADDR), .DST_INC(DST_INC), .CW(CW)) u_addr_gen (
    .i_state    (r_state),
    .i_page     (r_page),
    .i_cnt      (r_cnt),
    .o_spr_addr (o_spr_addr)
  );
endmodule

// File: tb/tb_spr_dma_engine.sv
// tb_spr_dma_engine: directed checks of the sprite DMA engine (default build and SPR_DMA_ABORT_EN build)
module tb_spr_dma_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [15:0] a_bus_addr = 16'h0, b_bus_addr = 16'h0;
  logic a_bus_wn = 1'b1, b_bus_wn = 1'b1;
  logic [7:0] a_bus_wdata = 8'h0, b_bus_wdata = 8'h0;
  logic a_gnt = 1'b0, b_gnt = 1'b0;
  logic a_busy, a_done, a_req, a_wn, b_busy, b_done, b_req, b_wn;
  logic [15:0] a_addr, b_addr;
  logic [7:0] a_wdata, a_rdata, b_wdata, b_rdata;
`ifdef SPR_DMA_ABORT_EN
  logic a_abort = 1'b0, b_abort = 1'b0;
`endif
  int n_chk = 0, n_err = 0;
  function automatic logic [7:0] src(input logic [15:0] ad);
    return ad[7:0] ^ ad[15:8] ^ 8'h5A;
  endfunction
  assign a_rdata = src(a_addr);
  assign b_rdata = src(b_addr);
  spr_dma_engine u_a (
`ifdef SPR_DMA_ABORT_EN
    .i_abort(a_abort),
`endif
    .i_clk(clk), .i_rst(rst), .i_bus_addr(a_bus_addr), .i_bus_wn(a_bus_wn), .i_bus_wdata(a_bus_wdata),
    .o_busy(a_busy), .o_done(a_done), .o_spr_req(a_req), .i_spr_gnt(a_gnt),
    .o_spr_addr(a_addr), .o_spr_wn(a_wn), .o_spr_wdata(a_wdata), .i_spr_rdata(a_rdata)
  );
  spr_dma_engine #(.DST_ADDR(16'h3000), .XFER_LEN(4), .DST_INC(1)) u_b (
`ifdef SPR_DMA_ABORT_EN
    .i_abort(b_abort),
`endif
    .i_clk(clk), .i_rst(rst), .i_bus_addr(b_bus_addr), .i_bus_wn(b_bus_wn), .i_bus_wdata(b_bus_wdata),
    .o_busy(b_busy), .o_done(b_done), .o_spr_req(b_req), .i_spr_gnt(b_gnt),
    .o_spr_addr(b_addr), .o_spr_wn(b_wn), .o_spr_wdata(b_wdata), .i_spr_rdata(b_rdata)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic trig_a(input logic [7:0] pg);
    tick;
    a_bus_addr = 16'h4014;
    a_bus_wn = 1'b0;
    a_bus_wdata = pg;
  endtask
  // full default transfer with an independent byte-sequence model; optional stall on byte 3 and mid-run retrigger
  task automatic run_a(input logic [7:0] pg, input bit stall, input bit retrig, input int exp_lat);
    int k = 0, ph = 0, w = 0, bad = 0, lat = 0, cyc = 0;
    logic g;
    a_gnt = 1'b0;
    trig_a(pg);
    while (cyc < 3000 && lat == 0) begin
      tick;
      cyc++;
      a_bus_wn = 1'b1;
      a_bus_wdata = 8'h00;
      if (retrig && cyc == 50) begin
        a_bus_wn = 1'b0;
        a_bus_wdata = 8'h07;
      end
      if (a_done) lat = cyc;
      else begin
        if (!a_busy || !a_req) bad++;
        else if (ph == 0 && (a_addr !== {pg, 8'h00} + 16'(k) || !a_wn)) bad++;
        else if (ph == 1 && (a_addr !== 16'h2004 || a_wn || a_wdata !== src({pg, 8'h00} + 16'(k)))) bad++;
        g = !(stall && k == 3 && w < (ph == 0 ? 3 : 2));
        a_gnt = g;
        if (!g) w++;
        else begin
          w = 0;
          if (ph == 1) k++;
          ph = 1 - ph;
        end
      end
    end
    a_gnt = 1'b0;
    a_bus_wn = 1'b0;
    a_bus_wdata = 8'h07;
    check("latency", lat, exp_lat);
    check("seq_bad_cycles", bad, 0);
    check("bytes_moved", k, 256);
    check("busy_in_done", a_busy, 1);
    tick;
    a_bus_wn = 1'b1;
    check("busy_fall_trig_ignored", a_busy, 0);
    check("done_single_pulse", a_done, 0);
    check("idle_req", a_req, 0);
  endtask
  initial begin
    int cyc, nr, nw, lat, bad;
    logic [15:0] rd [8];
    logic [15:0] wa [8];
    logic [7:0] wd [8];
    repeat (2) tick;
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_req", a_req, 0);
    check("rst_wn", a_wn, 1);
    check("rst_addr", a_addr, 16'h0);
    check("rst_wdata", a_wdata, 8'h00);
    check("rst_b_busy", b_busy, 0);
    rst = 1'b0;
    tick;
    a_bus_addr = 16'h4015;
    a_bus_wn = 1'b0;
    tick;
    a_bus_addr = 16'h4014;
    a_bus_wn = 1'b1;
    tick;
    check("wrong_addr_ignored", a_busy, 0);
    tick;
    check("read_trig_ignored", a_busy, 0);
    run_a(8'h02, 1'b0, 1'b0, 513);
    run_a(8'h05, 1'b1, 1'b0, 518);
    run_a(8'h0C, 1'b0, 1'b1, 513);
    // reset during byte 10 write phase
    a_gnt = 1'b1;
    trig_a(8'h11);
    for (int i = 0; i < 22; i++) begin
      tick;
      a_bus_wn = 1'b1;
    end
    check("byte10_wr_addr", a_addr, 16'h2004);
    check("byte10_wr_wdata", a_wdata, src(16'h110A));
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("mid_rst_req", a_req, 0);
    check("mid_rst_busy", a_busy, 0);
    check("mid_rst_done", a_done, 0);
    check("mid_rst_addr", a_addr, 16'h0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (a_done || a_req) bad++;
    end
    check("post_rst_quiet", bad, 0);
    run_a(8'h22, 1'b0, 1'b0, 513);
    // incrementing destination, short transfer, top page
    b_gnt = 1'b1;
    tick;
    b_bus_addr = 16'h4014;
    b_bus_wn = 1'b0;
    b_bus_wdata = 8'hFF;
    nr = 0;
    nw = 0;
    lat = 0;
    cyc = 0;
    while (cyc < 40 && lat == 0) begin
      tick;
      cyc++;
      b_bus_wn = 1'b1;
      if (b_done) lat = cyc;
      else if (b_req && b_wn && nr < 8) begin
        rd[nr] = b_addr;
        nr++;
      end else if (b_req && !b_wn && nw < 8) begin
        wa[nw] = b_addr;
        wd[nw] = b_wdata;
        nw++;
      end
    end
    check("b_latency", lat, 9);
    check("b_reads", nr, 4);
    check("b_writes", nw, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b_rd_addr%0d", i), rd[i], 16'hFF00 + 16'(i));
      check($sformatf("b_wr_addr%0d", i), wa[i], 16'h3000 + 16'(i));
      check($sformatf("b_wr_data%0d", i), wd[i], src(16'hFF00 + 16'(i)));
    end
    tick;
    check("b_busy_fall", b_busy, 0);
`ifdef SPR_DMA_ABORT_EN
    a_gnt = 1'b1;
    trig_a(8'h33);
    for (int i = 0; i < 12; i++) begin
      tick;
      a_bus_wn = 1'b1;
    end
    check("abort_at_wr5", a_wn, 0);
    check("abort_wr5_data", a_wdata, src(16'h3305));
    a_abort = 1'b1;
    tick;
    a_abort = 1'b0;
    check("abort_busy", a_busy, 0);
    check("abort_req", a_req, 0);
    check("abort_done", a_done, 0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (a_done || a_busy) bad++;
    end
    check("abort_quiet", bad, 0);
    a_abort = 1'b1;
    tick;
    a_abort = 1'b0;
    check("abort_idle_noop", a_busy, 0);
    run_a(8'h44, 1'b0, 1'b0, 513);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/spr_dma_engine.md
SPR_DMA_ENGINE -- requirements
Module: spr_dma_engine

Interface
REQ-001 Parameter TRIG_ADDR, default 16'h4014, CPU bus address whose write starts a transfer and supplies the source page.
REQ-002 Parameter DST_ADDR, default 16'h2004, first destination address.
REQ-003 Parameter XFER_LEN, default 256, range 1..4096, bytes moved per transfer.
REQ-004 Parameter DST_INC, default 0; 0 = fixed destination (port write), 1 = destination increments per byte.
REQ-005 Ports:
- i_clk, input, 1: clock, the only clock.
- i_rst, input, 1: synchronous, active-high reset.
- i_bus_addr / i_bus_wn / i_bus_wdata, input, 16/1/8: CPU slave bus; i_bus_wn low = write.
- o_busy, output, 1: CPU stall, high while a transfer is in progress.
- o_done, output, 1: one-cycle pulse when the last byte is written.
- o_spr_req, output, 1: master bus request.
- i_spr_gnt, input, 1: master grant.
- o_spr_addr / o_spr_wn / o_spr_wdata, output, 16/1/8: master address, write-not, write data.
- i_spr_rdata, input, 8: master read data, valid in any cycle where i_spr_gnt is high during a read.

Function
REQ-006 States SHALL be IDLE, RD, WR and DONE, with these transitions:
- IDLE->RD on a trigger write (i_bus_addr==TRIG_ADDR, i_bus_wn==0).
- RD->WR on i_spr_gnt.
- WR->RD on i_spr_gnt with bytes remaining.
- WR->DONE on i_spr_gnt for the last byte.
- DONE->IDLE unconditionally.
REQ-007 On the trigger cycle, the page register SHALL capture i_bus_wdata, and the byte counter and destination offset SHALL clear to 0.
REQ-008 In RD: o_spr_req=1, o_spr_wn=1, o_spr_addr={page,8'h00}+cnt, computed modulo 2^16 (wrap FFFF->0000).
REQ-009 On RD with i_spr_gnt, the data buffer SHALL capture i_spr_rdata.
REQ-010 In WR: o_spr_req=1, o_spr_wn=0, o_spr_wdata=buffer, o_spr_addr=DST_ADDR+(DST_INC ? cnt : 0), modulo 2^16.
REQ-011 The counter width SHALL be $clog2(XFER_LEN+1); the counter SHALL increment on WR with i_spr_gnt, and the last byte is reached when cnt==XFER_LEN-1.
REQ-012 With no grant, RD and WR SHALL hold state, address and data indefinitely.
REQ-013 In IDLE and DONE: o_spr_req=0, o_spr_wn=1, o_spr_addr=16'h0.
REQ-014 o_busy SHALL be high in RD, WR and DONE, and low in IDLE.
REQ-015 o_done SHALL be high only in DONE.
REQ-016 Trigger writes while not in IDLE SHALL be ignored; the page register SHALL not change.
REQ-017 A trigger in the same cycle as DONE->IDLE SHALL be ignored.
REQ-018 Total transfer latency with permanent grant SHALL be 2*XFER_LEN+1 cycles from the trigger edge to o_done.

Reset
REQ-019 i_rst sampled high SHALL force IDLE, cnt=0, page=8'h00, buffer=8'h00, o_busy=0, o_done=0, o_spr_req=0, o_spr_wn=1.
REQ-020 Reset mid-transfer SHALL abandon the transfer without an o_done pulse, and no further master write SHALL be issued.

Configuration
REQ-021 With SPR_DMA_ABORT_EN defined, the module SHALL add input i_abort (1 bit).
REQ-022 i_abort high in RD or WR SHALL force IDLE on the next edge, with no o_done pulse; the current unaccepted request SHALL be dropped.
REQ-023 i_abort SHALL take priority over a simultaneous grant.
REQ-024 i_abort in IDLE or DONE SHALL have no effect.
REQ-025 Without SPR_DMA_ABORT_EN, the port SHALL not exist and transfers SHALL always run to completion.

Structure
REQ-026 A shared package spr_dma_pkg SHALL hold the state encoding (IDLE=2'd0, RD=2'd1, WR=2'd2, DONE=2'd3) and the default TRIG_ADDR and DST_ADDR constants.
REQ-027 The address generator SHALL be a single sub-module, spr_dma_addr_gen, taking state, page and cnt and producing o_spr_addr.
REQ-028 All remaining logic SHALL be flat within spr_dma_engine.

Verification
REQ-029 Default parameters, permanent grant, write 8'h02 to 4014:
- reads 0200..02FF alternate with 256 writes to 2004;
- o_done occurs exactly 513 cycles after the trigger;
- o_busy falls one cycle after o_done.
REQ-030 Grant withheld for 3 cycles in RD and 2 cycles in WR:
- address and data remain stable throughout each stall;
- the byte sequence is unchanged;
- latency extends by exactly 5 cycles.
REQ-031 DST_INC=1, DST_ADDR=16'h3000, XFER_LEN=4, page 8'hFF:
- reads FF00..FF03;
- writes to 3000..3003 carry the read bytes in order.
REQ-032 Second trigger write of 8'h07 issued mid-transfer:
- ignored;
- sources stay on the original page;
- exactly one o_done pulse.
REQ-033 i_rst asserted during byte 10:
- next cycle is IDLE with o_spr_req=0;
- no o_done pulse;
- a new trigger restarts from cnt=0.
REQ-034 With SPR_DMA_ABORT_EN, i_abort asserted together with i_spr_gnt in WR at cnt=5:
- returns to IDLE;
- the write is not counted;
- no o_done pulse.
